// File: rtl/interpolator_powers_of_two.sv
// Linear-interpolating upsampler: each input point C yields 2**N samples stepping
// from the previous point P to C, using an accumulator and an arithmetic shift.
module interpolator_powers_of_two #(
  parameter int WORD_WIDTH            = 8,
  parameter int POWER_OF_TWO_EXPONENT = 0
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  restart_interpolation,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] input_sample,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_sample
);
  localparam int W  = WORD_WIDTH;
  localparam int N  = POWER_OF_TWO_EXPONENT;
  localparam int AW = W + N + 1;
  localparam int DW = W + 1;
  localparam int CW = N + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(1) << N;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]           r_state;
  logic signed [W-1:0]  r_p;
  logic signed [W-1:0]  r_c;
  logic signed [AW-1:0] r_acc;
  logic signed [DW-1:0] r_delta;
  logic [CW-1:0]        r_count;
  logic                 r_restart_q;

  logic                 w_restart;
  logic signed [W-1:0]  w_c;
  logic signed [DW-1:0] w_delta;
  logic signed [AW-1:0] w_acc_init;

  assign w_restart  = restart_interpolation & ~r_restart_q;
  assign w_c        = $signed(input_sample);
  assign w_delta    = DW'(w_c) - DW'(r_p);
  // First step is already one delta past P, so sample k=1 appears right after accept.
  assign w_acc_init = (AW'(r_p) <<< N) + AW'(w_delta);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state     <= IDLE;
      r_p         <= '0;
      r_c         <= '0;
      r_acc       <= '0;
      r_delta     <= '0;
      r_count     <= '0;
      r_restart_q <= 1'b0;
    end else begin
      r_restart_q <= restart_interpolation;
      if (w_restart) begin
        r_state <= IDLE;
        r_p     <= '0;
        r_acc   <= '0;
        r_count <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (input_valid) begin
              r_delta <= w_delta;
              r_acc   <= w_acc_init;
              r_count <= FULL_CNT;
              r_c     <= w_c;
              r_state <= EMIT;
            end
          end
          default: begin
            if (output_ready) begin
              if (r_count == CW'(1)) begin
                r_p     <= r_c;
                r_state <= IDLE;
              end else begin
                r_acc   <= r_acc + AW'(r_delta);
                r_count <= r_count - CW'(1);
              end
            end
          end
        endcase
      end
    end
  end

  // acc stays within [P<<N, C<<N], so dropping the guard bit never wraps.
  assign input_ready   = (r_state == IDLE);
  assign output_valid  = (r_state == EMIT);
  assign output_sample = r_acc[W+N-1:N];

endmodule

// File: tb/tb_interpolator_powers_of_two.sv
// Scoreboard bench: N=2 and N=0 instances, directed vectors with hand-computed samples.
module tb_interpolator_powers_of_two;
  logic clock = 1'b0;
  logic clear_n = 1'b0;

  logic       a_restart = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b1;
  logic       a_in_ready, a_out_valid;
  logic [7:0] a_in_sample = '0, a_out_sample;

  logic       b_restart = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic       b_in_ready, b_out_valid;
  logic [7:0] b_in_sample = '0, b_out_sample;

  int checks = 0;
  int failures = 0;
  int qa[$];
  int qb[$];

  always #5 clock = ~clock;

  interpolator_powers_of_two #(.WORD_WIDTH(8), .POWER_OF_TWO_EXPONENT(2)) dut (
    .clock(clock), .clear_n(clear_n), .restart_interpolation(a_restart),
    .input_valid(a_in_valid), .input_ready(a_in_ready), .input_sample(a_in_sample),
    .output_valid(a_out_valid), .output_ready(a_out_ready), .output_sample(a_out_sample));

  interpolator_powers_of_two #(.WORD_WIDTH(8), .POWER_OF_TWO_EXPONENT(0)) dut0 (
    .clock(clock), .clear_n(clear_n), .restart_interpolation(b_restart),
    .input_valid(b_in_valid), .input_ready(b_in_ready), .input_sample(b_in_sample),
    .output_valid(b_out_valid), .output_ready(b_out_ready), .output_sample(b_out_sample));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (clear_n && a_out_valid && a_out_ready) begin
      checks++;
      if (qa.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_sample actual=%0d expected=none", $signed(a_out_sample));
      end else begin
        int e;
        e = qa.pop_front();
        if (int'($signed(a_out_sample)) != e) begin
          failures++;
          $display("FAIL a_sample actual=%0d expected=%0d", $signed(a_out_sample), e);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (clear_n && b_out_valid && b_out_ready) begin
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected_sample actual=%0d expected=none", $signed(b_out_sample));
      end else begin
        int e;
        e = qb.pop_front();
        if (int'($signed(b_out_sample)) != e) begin
          failures++;
          $display("FAIL b_sample actual=%0d expected=%0d", $signed(b_out_sample), e);
        end
      end
    end
  end

  task automatic accept_a(input int v);
    @(negedge clock);
    chk("a_in_ready_pre", int'(a_in_ready), 1);
    a_in_valid  = 1'b1;
    a_in_sample = 8'(v);
    @(posedge clock);
    #1 a_in_valid = 1'b0;
  endtask

  // Full sequence with output_ready high: 4 valid cycles, then input_ready back.
  task automatic send_a(input int v, input int s1, input int s2, input int s3, input int s4);
    qa.push_back(s1); qa.push_back(s2); qa.push_back(s3); qa.push_back(s4);
    accept_a(v);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("a_valid_during", int'(a_out_valid), 1);
      chk("a_in_ready_during", int'(a_in_ready), 0);
    end
    @(negedge clock);
    chk("a_valid_after", int'(a_out_valid), 0);
    chk("a_in_ready_after", int'(a_in_ready), 1);
    chk("a_queue_empty", qa.size(), 0);
  endtask

  task automatic wait_drain_a();
    int n = 0;
    while (qa.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("a_drain", qa.size(), 0);
  endtask

  task automatic send_b(input int v);
    qb.push_back(v);
    @(negedge clock);
    chk("b_in_ready_pre", int'(b_in_ready), 1);
    b_in_valid  = 1'b1;
    b_in_sample = 8'(v);
    @(posedge clock);
    #1 b_in_valid = 1'b0;
    @(negedge clock);
    chk("b_valid_during", int'(b_out_valid), 1);
    chk("b_in_ready_during", int'(b_in_ready), 0);
    @(negedge clock);
    chk("b_valid_after", int'(b_out_valid), 0);
    chk("b_in_ready_after", int'(b_in_ready), 1);
    chk("b_queue_empty", qb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_valid", int'(a_out_valid), 0);
    chk("rst_sample", int'($signed(a_out_sample)), 0);
    chk("rst_in_ready", int'(a_in_ready), 1);
    chk("rst_b_valid", int'(b_out_valid), 0);
    repeat (2) @(negedge clock);
    clear_n = 1'b1;

    // Ramps, floor rounding, full-scale swing
    send_a(8, 2, 4, 6, 8);
    send_a(0, 6, 4, 2, 0);
    send_a(-3, -1, -2, -3, -3);
    send_a(0, -3, -2, -1, 0);
    send_a(-128, -32, -64, -96, -128);
    send_a(127, -65, -1, 63, 127);

    // Backpressure: 127 -> 7, stall on the second sample
    qa.push_back(97); qa.push_back(67); qa.push_back(37); qa.push_back(7);
    accept_a(7);
    @(posedge clock);
    #1 a_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_valid", int'(a_out_valid), 1);
      chk("bp_sample", int'($signed(a_out_sample)), 67);
      chk("bp_in_ready", int'(a_in_ready), 0);
    end
    @(posedge clock);
    #1 a_out_ready = 1'b1;
    wait_drain_a();
    @(negedge clock);
    chk("bp_in_ready_after", int'(a_in_ready), 1);

    // Restart after two samples of 7 -> 12; third sample is consumed in the restart cycle
    qa.push_back(8); qa.push_back(9); qa.push_back(10);
    accept_a(12);
    @(posedge clock);
    @(posedge clock);
    #1 a_restart = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("rs_valid", int'(a_out_valid), 0);
    chk("rs_in_ready", int'(a_in_ready), 1);
    chk("rs_queue_empty", qa.size(), 0);
    send_a(4, 1, 2, 3, 4);
    a_restart = 1'b0;

    // Async reset mid-EMIT: 4 -> 8, reset after first sample
    qa.push_back(5);
    accept_a(8);
    @(posedge clock);
    #2 clear_n = 1'b0;
    #1;
    chk("ar_valid", int'(a_out_valid), 0);
    chk("ar_sample", int'($signed(a_out_sample)), 0);
    chk("ar_in_ready", int'(a_in_ready), 1);
    chk("ar_queue_empty", qa.size(), 0);
    @(negedge clock);
    clear_n = 1'b1;
    send_a(4, 1, 2, 3, 4);

    // N = 0 pass-through
    send_b(5);
    send_b(-7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
